// File: rtl/data_memory.sv
// Word-organised data memory: combinational read, synchronous write, async clear.
// Optional DATA_MEMORY_BOUNDS_CHECK_EN: out-of-range addresses read zero and drop writes.
module data_memory #(
   parameter int unsigned DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        WE,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   output logic [31:0] RD
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];
   logic [IDX_W-1:0] idx;
   logic             in_range;

   assign idx = A[IDX_W+1:2];

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
   logic unused_addr;
   assign in_range    = (A[31:IDX_W+2] == '0);
   assign unused_addr = ^A[1:0];
`else
   // Upper address bits are dropped so addresses wrap modulo DEPTH words.
   logic unused_addr;
   assign in_range    = 1'b1;
   assign unused_addr = ^{A[1:0], A[31:IDX_W+2]};
`endif

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (WE && in_range) begin
         mem_d[idx] = WD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   always_comb begin
      RD = 32'h0;
      if (in_range) begin
         RD = mem_q[idx];
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with hand-computed expected values.
module tb_data_memory;

   localparam int unsigned DEPTH = 64;

   logic        clk;
   logic        rst_n;
   logic        WE;
   logic [31:0] A;
   logic [31:0] WD;
   logic [31:0] RD;

   int n_tests = 0;
   int n_fail  = 0;

   data_memory #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .WE    (WE),
      .A     (A),
      .WD    (WD),
      .RD    (RD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change just after a negedge; writes land on the following posedge.
   task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      A  = addr;
      WD = data;
      WE = 1'b1;
      @(posedge clk);
      #1;
      WE = 1'b0;
   endtask

   task automatic read_at(input logic [31:0] addr);
      A = addr;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      WE    = 1'b0;
      A     = 32'd0;
      WD    = 32'd0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      read_at(32'd10);
      check("reset_a10", RD, 32'h0000_0000);
      read_at(32'd20);
      check("reset_a20", RD, 32'h0000_0000);

      // Read-during-write: old word before the edge, new word after.
      @(negedge clk);
      A  = 32'd10;
      WD = 32'd12345678;
      WE = 1'b1;
      #1;
      check("rdw_before_edge", RD, 32'h0000_0000);
      @(posedge clk);
      #1;
      WE = 1'b0;
      check("write_a10", RD, 32'h00BC_614E);
      @(posedge clk);
      #1;
      check("persist_a10", RD, 32'h00BC_614E);

      write_word(32'd20, 32'd87654321);
      check("write_a20", RD, 32'h0539_7FB1);
      read_at(32'd10);
      check("a10_kept", RD, 32'h00BC_614E);

      @(negedge clk);
      A  = 32'd10;
      WD = 32'hDEAD_BEEF;
      WE = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("we0_hold", RD, 32'h00BC_614E);
      read_at(32'd8);
      check("a8_same_word", RD, 32'h00BC_614E);
      read_at(32'd11);
      check("a11_same_word", RD, 32'h00BC_614E);
      read_at(32'd0);
      check("word0_clear", RD, 32'h0000_0000);

      write_word(4 * DEPTH, 32'hCAFE_F00D);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
      check("oob_read_zero", RD, 32'h0000_0000);
      read_at(32'd0);
      check("oob_word0_kept", RD, 32'h0000_0000);
`else
      check("wrap_read", RD, 32'hCAFE_F00D);
      read_at(32'd0);
      check("wrap_word0", RD, 32'hCAFE_F00D);
      read_at(4 * DEPTH + 10);
      check("wrap_alias_w2", RD, 32'h00BC_614E);
`endif

      // Async reset between edges, then a write attempt while held low.
      @(negedge clk);
      A = 32'd10;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_a10", RD, 32'h0000_0000);
      read_at(32'd20);
      check("async_rst_a20", RD, 32'h0000_0000);
      WD = 32'h1234_5678;
      WE = 1'b1;
      @(posedge clk);
      #1;
      check("write_blocked_rst", RD, 32'h0000_0000);
      WE = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("after_rst_a20", RD, 32'h0000_0000);
      read_at(32'd0);
      check("after_rst_w0", RD, 32'h0000_0000);

      write_word(32'd252, 32'h0F0F_0F0F);
      check("last_word", RD, 32'h0F0F_0F0F);
      read_at(32'd248);
      check("last_minus1", RD, 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
